// File: rtl/sram_responder_pkg.sv
// sram_responder_pkg: shared widths, wait-FSM encoding and byte-lane merge helper
package sram_responder_pkg;
  localparam int SRAM_DW = 32;
  localparam int SRAM_BE_W = 4;
  localparam int WAIT_CNT_W = 4;
  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} wait_st_e;
  function automatic logic [SRAM_DW-1:0] be_merge(input logic [SRAM_DW-1:0] old_w, input logic [SRAM_DW-1:0] new_w, input logic [SRAM_BE_W-1:0] be);
    logic [SRAM_DW-1:0] r;
    for (int i = 0; i < SRAM_BE_W; i++) r[8*i+:8] = be[i] ? new_w[8*i+:8] : old_w[8*i+:8];
    return r;
  endfunction
endpackage

// File: rtl/sram_bank_be.sv
// sram_bank_be: 1R + 1RW byte-enable word array, registered reads, write-first on collision
module sram_bank_be
  import sram_responder_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_en,
  input  logic [AW-1:0]        a_idx,
  output logic [SRAM_DW-1:0]   a_q,
  input  logic                 b_en,
  input  logic [SRAM_BE_W-1:0] b_we,
  input  logic [AW-1:0]        b_idx,
  input  logic [SRAM_DW-1:0]   b_wd,
  output logic [SRAM_DW-1:0]   b_q
);
  logic [SRAM_DW-1:0] mem [2**AW];
  logic               b_wr;
  logic [SRAM_DW-1:0] a_word;
  assign b_wr = b_en && |b_we;
  // the read port sees the merged word when the RW port writes the same word this edge
  assign a_word = (b_wr && b_idx == a_idx) ? be_merge(mem[b_idx], b_wd, b_we) : mem[a_idx];
  always_ff @(posedge clk) begin
    for (int i = 0; i < SRAM_BE_W; i++)
      if (b_wr && b_we[i]) mem[b_idx][8*i+:8] <= b_wd[8*i+:8];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (a_en) a_q <= a_word;
      if (b_en && !(|b_we)) b_q <= mem[b_idx];
    end
  end
endmodule

// File: rtl/sram_responder.sv
// sram_responder: inst/data sram responder over one shared array; SRAM_RSP_WAIT_EN adds data-port wait states
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int AW = 14,
  parameter int WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq
);
  logic d_go;
  logic unused_bits;
  assign unused_bits = ^{inst_sram_wen, inst_sram_wdata, inst_sram_addr[31:AW+2], inst_sram_addr[1:0],
                         data_sram_addr[31:AW+2], data_sram_addr[1:0]};
`ifdef SRAM_RSP_WAIT_EN
  localparam logic [WAIT_CNT_W-1:0] WAIT_LD = WAIT_CNT_W'(WAIT_CYC > 0 ? WAIT_CYC - 1 : 0);
  wait_st_e st, st_nx;
  logic [WAIT_CNT_W-1:0] cnt, cnt_nx;
  logic stall_raw, go_raw;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st  <= ST_IDLE;
      cnt <= '0;
    end else begin
      st  <= st_nx;
      cnt <= cnt_nx;
    end
  end
  always_comb begin
    st_nx = st;
    cnt_nx = cnt;
    stall_raw = 1'b0;
    go_raw = 1'b0;
    if (WAIT_CYC == 0) go_raw = data_sram_en;
    else if (st == ST_IDLE) begin
      stall_raw = data_sram_en;
      st_nx = data_sram_en ? ST_WAIT : ST_IDLE;
      cnt_nx = data_sram_en ? WAIT_LD : cnt;
    end else begin
      stall_raw = cnt != '0;
      cnt_nx = (cnt != '0) ? cnt - 1'b1 : cnt;
      go_raw = (cnt == '0) && data_sram_en;
      st_nx = (cnt == '0) ? ST_IDLE : ST_WAIT;
    end
  end
  // reset forces both the stall request and any commit low immediately
  assign stallreq = stall_raw && rst;
  assign d_go = go_raw && rst;
`else
  logic unused_wait;
  assign unused_wait = WAIT_CYC != 0;
  assign stallreq = 1'b0;
  assign d_go = data_sram_en && rst;
`endif
  sram_bank_be #(.AW(AW)) u_bank (
    .clk  (clk),
    .rst  (rst),
    .a_en (inst_sram_en),
    .a_idx(inst_sram_addr[AW+1:2]),
    .a_q  (inst_sram_rdata),
    .b_en (d_go),
    .b_we (data_sram_wen),
    .b_idx(data_sram_addr[AW+1:2]),
    .b_wd (data_sram_wdata),
    .b_q  (data_sram_rdata)
  );
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: scoreboard bench against a byte-addressed memory model
module tb_sram_responder;
  localparam int AW = 14;
  localparam int WAIT_CYC = 2;
`ifdef SRAM_RSP_WAIT_EN
  localparam int EXP_STALL = WAIT_CYC;
`else
  localparam int EXP_STALL = 0;
`endif
  logic clk = 0, rst = 0;
  logic inst_sram_en = 0, data_sram_en = 0, stallreq;
  logic [3:0] inst_sram_wen = 0, data_sram_wen = 0;
  logic [31:0] inst_sram_addr = 0, inst_sram_wdata = 0, inst_sram_rdata;
  logic [31:0] data_sram_addr = 0, data_sram_wdata = 0, data_sram_rdata;
  sram_responder #(.AW(AW), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .rst(rst),
    .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_rdata(data_sram_rdata), .stallreq(stallreq)
  );
  always #5 clk = ~clk;
  int cyc = 0, n_chk = 0, n_fail = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [7:0] mb [1024];
  typedef struct {int due; logic [31:0] v;} exp_t;
  exp_t iq[$], dq[$];
  function automatic int mbase(input logic [31:0] a);
    return int'((a >> 2) & 32'd255) * 4;
  endfunction
  function automatic logic [31:0] mword(input logic [31:0] a);
    int b = mbase(a);
    return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
  endfunction
  function automatic logic [31:0] rand_addr();
    logic [31:0] hi = $urandom;
    return (hi << (AW + 2)) | ($urandom_range(0, 255) << 2) | $urandom_range(0, 3);
  endfunction
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    while (iq.size() > 0 && iq[0].due <= cyc) begin
      e = iq.pop_front();
      check("inst_rdata", inst_sram_rdata, e.v);
    end
    while (dq.size() > 0 && dq[0].due <= cyc) begin
      e = dq.pop_front();
      check("data_rdata", data_sram_rdata, e.v);
    end
  end
  task automatic cyc_op(input logic ien, input logic [31:0] ia, input logic [3:0] iw, input logic den,
                        input logic [3:0] dw, input logic [31:0] da, input logic [31:0] wd);
    int n = 0;
    bit done = 0;
    int b;
    exp_t e;
    @(posedge clk); #1;
    inst_sram_en = ien; inst_sram_addr = ia; inst_sram_wen = iw; inst_sram_wdata = $urandom;
    data_sram_en = den; data_sram_wen = dw; data_sram_addr = da; data_sram_wdata = wd;
    while (!done) begin
      @(negedge clk);
      done = !(den && stallreq);
      if (!done && n >= 20) begin
        n_chk++; n_fail++;
        $display("FAIL stall_timeout: stallreq still high after %0d cycles, required release", n);
        done = 1;
      end else begin
        if (done && den && dw != 0) begin
          b = mbase(da);
          for (int i = 0; i < 4; i++) if (dw[i]) mb[b+i] = wd[8*i+:8];
        end
        if (ien) begin e.due = cyc + 1; e.v = mword(ia); iq.push_back(e); end
        if (done && den && dw == 0) begin e.due = cyc + 1; e.v = mword(da); dq.push_back(e); end
        if (done && den) check("stall_cycles", n, EXP_STALL);
        if (!done) begin n++; @(posedge clk); #1; end
      end
    end
  endtask
  initial begin
    logic [31:0] v;
    repeat (3) @(negedge clk);
    check("reset_inst_rdata", inst_sram_rdata, 0);
    check("reset_data_rdata", data_sram_rdata, 0);
    check("reset_stallreq", {31'd0, stallreq}, 0);
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    check("post_release_inst_rdata", inst_sram_rdata, 0);
    for (int w = 0; w < 256; w++) begin
      v = (w == 0) ? 32'h24020001 : (w == 64) ? 32'h11223344 : $urandom;
      cyc_op(0, 0, 0, 1, 4'hf, w * 4, v);
    end
    cyc_op(1, 32'h0, 0, 0, 0, 0, 0);
    cyc_op(0, 0, 0, 1, 4'b0101, 32'h100, 32'hAABBCCDD);
    cyc_op(0, 0, 0, 1, 4'h0, 32'h100, 0);
    cyc_op(0, 0, 0, 0, 0, 0, 0);
    check("byte_lane_merge", data_sram_rdata, 32'h11BB33DD);
    cyc_op(1, 32'h200, 0, 1, 4'hf, 32'h200, 32'hDEADBEEF);
    cyc_op(0, 0, 0, 0, 0, 0, 0);
    check("collision_write_first", inst_sram_rdata, 32'hDEADBEEF);
    cyc_op(1, 32'h40, 4'hf, 0, 0, 0, 0);
    cyc_op(1, 32'h40, 0, 1, 4'h0, 32'h40 + (32'd4 << AW), 0);
    cyc_op(0, 32'h203, 0, 1, 4'h0, 32'h200 + (32'd9 << (AW + 2)), 0);
    for (int k = 0; k < 400; k++)
      cyc_op(1'($urandom_range(0, 3) != 0), rand_addr(), 4'($urandom), 1'($urandom_range(0, 3) != 0),
             $urandom_range(0, 1) ? 4'h0 : 4'($urandom), rand_addr(), $urandom);
    cyc_op(0, 0, 0, 0, 0, 0, 0);
    v = mword(32'h80);
    @(posedge clk); #1;
    inst_sram_en = 1; inst_sram_addr = 32'h84; inst_sram_wen = 0;
    data_sram_en = 1; data_sram_wen = 4'hf; data_sram_addr = 32'h80; data_sram_wdata = ~v;
    #2 rst = 0;
    #1;
    check("midreset_inst_rdata", inst_sram_rdata, 0);
    check("midreset_data_rdata", data_sram_rdata, 0);
    check("midreset_stallreq", {31'd0, stallreq}, 0);
    @(posedge clk); #1;
    rst = 1; inst_sram_en = 0; data_sram_en = 0;
    @(negedge clk);
    check("after_reset_data_rdata", data_sram_rdata, 0);
    cyc_op(1, 32'h80, 0, 1, 4'h0, 32'h80, 0);
    cyc_op(0, 0, 0, 0, 0, 0, 0);
    check("reset_blocked_write", data_sram_rdata, v);
    cyc_op(0, 0, 0, 0, 0, 0, 0);
    check("scoreboard_drained", iq.size() + dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
